// File: rtl/dh_ctrl_pkg.sv
// Shared types and verdict constants for the DH acceptance sequencer.
// Each verdict is a 48-bit ASCII word with the first character in the MSBs.
package dh_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        PASS  = 3'd2,
        FAIL  = 3'd3,
        TOUT  = 3'd4
    } state_t;

    localparam logic [47:0] MSG_ACCEPT = 48'h414343455054; // "ACCEPT"
    localparam logic [47:0] MSG_REJECT = 48'h52454A454354; // "REJECT"
    localparam logic [47:0] MSG_EXPIRE = 48'h455850495245; // "EXPIRE"

endpackage

// File: rtl/dh_step_timer.sv
// Per-step timeout counter. A clear loads TIMEOUT_CYC-1, and the counter then steps down to zero and stays there.
// expire is asserted while the count is zero. A zero TIMEOUT_CYC ties expire low.
module dh_step_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            logic unused_in;
            assign unused_in = ^{clk, rst, clear, enable};
            assign expire    = 1'b0;
        end else begin : g_on
            logic [TW-1:0] cnt;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    cnt <= '0;
                else if (clear)
                    cnt <= TW'(TIMEOUT_CYC - 1);
                else if (enable && cnt != '0)
                    cnt <= cnt - TW'(1);
            end

            assign expire = (cnt == '0);
        end
    endgenerate

endmodule

// File: rtl/dh_verify_sequencer.sv
// Steps through NUM_CHECKS datapath verification results in order and latches a sticky ASCII verdict.
// All outputs are registered copies of the next-state decode, so no input reaches an output combinationally.
module dh_verify_sequencer
    import dh_ctrl_pkg::*;
#(
    parameter  int NUM_CHECKS  = 2,
    parameter  int TIMEOUT_CYC = 16,
    localparam int SEL_W       = ($clog2(NUM_CHECKS) > 0) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             chk_vld,
    input  logic             chk_ok,
    output logic [SEL_W-1:0] chk_sel,
    output logic             busy,
    output logic             done,
    output logic             accept,
    output logic [47:0]      out
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CHECKS - 1);

    state_t           state, state_n;
    logic [SEL_W-1:0] sel_n;
    logic [47:0]      out_n;
    logic             done_n;
    logic             tmr_clr, tmr_en, tmr_exp;

    dh_step_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (tmr_clr),
        .enable(tmr_en),
        .expire(tmr_exp)
    );

    always_comb begin
        state_n = state;
        sel_n   = chk_sel;
        out_n   = out;
        done_n  = 1'b0;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n = CHECK;
                    sel_n   = '0;
                    out_n   = '0;
                    tmr_clr = 1'b1;
                end
            end
            CHECK: begin
                if (abort) begin
                    state_n = IDLE;
                    sel_n   = '0;
                    out_n   = '0;
                end else if (chk_vld && !chk_ok) begin
                    state_n = FAIL;
                    out_n   = MSG_REJECT;
                    done_n  = 1'b1;
                end else if (chk_vld && chk_sel == LAST_SEL) begin
                    state_n = PASS;
                    out_n   = MSG_ACCEPT;
                    done_n  = 1'b1;
                end else if (chk_vld) begin
                    sel_n   = chk_sel + SEL_W'(1);
                    tmr_clr = 1'b1;
                end else if (tmr_exp) begin
                    state_n = TOUT;
                    out_n   = MSG_EXPIRE;
                    done_n  = 1'b1;
                end else begin
                    tmr_en  = 1'b1;
                end
            end
            PASS, FAIL, TOUT: begin
                // chk_sel keeps the deciding step index until the verdict is cleared
                if (abort) begin
                    state_n = IDLE;
                    sel_n   = '0;
                    out_n   = '0;
                end else if (start) begin
                    state_n = CHECK;
                    sel_n   = '0;
                    out_n   = '0;
                    tmr_clr = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                sel_n   = '0;
                out_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            chk_sel <= '0;
            out     <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            accept  <= 1'b0;
        end else begin
            state   <= state_n;
            chk_sel <= sel_n;
            out     <= out_n;
            done    <= done_n;
            busy    <= (state_n == CHECK);
            accept  <= (state_n == PASS);
        end
    end

endmodule

// File: tb/tb_dh_verify_sequencer.sv
// Scoreboard bench that drives three sequencer configurations from a single clock:
// (2 steps, timeout 16), (4 steps, timeout 16) and (1 step, timeout disabled).
module tb_dh_verify_sequencer;

    localparam logic [47:0] ACC = 48'h414343455054;
    localparam logic [47:0] REJ = 48'h52454A454354;
    localparam logic [47:0] EXP = 48'h455850495245;

    typedef struct {
        int          d;
        logic [47:0] o;
        logic        a;
        logic [1:0]  s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic st[3], ab[3], cv[3], co[3];
    logic [47:0] outv[3];
    logic [1:0]  selv[3];
    logic busyv[3], donev[3], accv[3];
    logic        s0, s2;
    logic [1:0]  s1;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    dh_verify_sequencer #(.NUM_CHECKS(2), .TIMEOUT_CYC(16)) u_d0 (
        .clk(clk), .rst(rst), .start(st[0]), .abort(ab[0]), .chk_vld(cv[0]), .chk_ok(co[0]),
        .chk_sel(s0), .busy(busyv[0]), .done(donev[0]), .accept(accv[0]), .out(outv[0]));
    dh_verify_sequencer #(.NUM_CHECKS(4), .TIMEOUT_CYC(16)) u_d1 (
        .clk(clk), .rst(rst), .start(st[1]), .abort(ab[1]), .chk_vld(cv[1]), .chk_ok(co[1]),
        .chk_sel(s1), .busy(busyv[1]), .done(donev[1]), .accept(accv[1]), .out(outv[1]));
    dh_verify_sequencer #(.NUM_CHECKS(1), .TIMEOUT_CYC(0)) u_d2 (
        .clk(clk), .rst(rst), .start(st[2]), .abort(ab[2]), .chk_vld(cv[2]), .chk_ok(co[2]),
        .chk_sel(s2), .busy(busyv[2]), .done(donev[2]), .accept(accv[2]), .out(outv[2]));

    assign selv[0] = {1'b0, s0};
    assign selv[1] = s1;
    assign selv[2] = {1'b0, s2};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_start(input int d);
        st[d] = 1'b1;
        tick(1);
        st[d] = 1'b0;
    endtask

    task automatic step(input int d, input logic ok);
        cv[d] = 1'b1;
        co[d] = ok;
        tick(1);
        cv[d] = 1'b0;
        co[d] = 1'b0;
    endtask

    task automatic push(input int d, input logic [47:0] o, input logic a, input logic [1:0] s);
        exp_t e;
        e.d = d; e.o = o; e.a = a; e.s = s;
        sb.push_back(e);
    endtask

    task automatic expect_st(input string tag, input int d, input logic b, input logic a,
                             input logic [1:0] s, input logic [47:0] o);
        chk({tag, "_busy"}, busyv[d], b);
        chk({tag, "_acc"},  accv[d],  a);
        chk({tag, "_sel"},  selv[d],  s);
        chk({tag, "_out"},  outv[d],  o);
    endtask

    // A done pulse must match the oldest pending expectation for the same instance.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (donev[d] === 1'b1) begin
                chk($sformatf("d%0d_done_expected", d), (sb.size() > 0 && sb[0].d == d), 1);
                if (sb.size() > 0 && sb[0].d == d) begin
                    e = sb.pop_front();
                    chk($sformatf("d%0d_sb_out", d),  outv[d],  e.o);
                    chk($sformatf("d%0d_sb_acc", d),  accv[d],  e.a);
                    chk($sformatf("d%0d_sb_sel", d),  selv[d],  e.s);
                    chk($sformatf("d%0d_sb_busy", d), busyv[d], 0);
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            st[d] = 0; ab[d] = 0; cv[d] = 0; co[d] = 0;
        end
        tick(2);
        for (int d = 0; d < 3; d++) begin
            expect_st($sformatf("d%0d_reset", d), d, 0, 0, 0, 0);
            chk($sformatf("d%0d_reset_done", d), donev[d], 0);
        end
        rst = 1'b1;
        tick(1);

        // T1 nominal two-step accept
        run_start(0);
        expect_st("t1_check", 0, 1, 0, 0, 0);
        step(0, 1);
        expect_st("t1_adv", 0, 1, 0, 1, 0);
        push(0, ACC, 1, 1);
        step(0, 1);
        chk("t1_done", donev[0], 1);
        tick(1);
        chk("t1_done_pulse", donev[0], 0);
        expect_st("t1_sticky", 0, 0, 1, 1, ACC);

        // T4 priority: abort wins over start, abort in CHECK, start ignored in CHECK
        st[0] = 1; ab[0] = 1;
        tick(1);
        st[0] = 0; ab[0] = 0;
        expect_st("t4_abort_start", 0, 0, 0, 0, 0);
        run_start(0);
        step(0, 1);
        ab[0] = 1; cv[0] = 1; co[0] = 1;
        tick(1);
        ab[0] = 0; cv[0] = 0; co[0] = 0;
        expect_st("t4_abort_vld", 0, 0, 0, 0, 0);
        run_start(0);
        step(0, 1);
        run_start(0);
        expect_st("t4_start_in_check", 0, 1, 0, 1, 0);
        push(0, ACC, 1, 1);
        step(0, 1);

        // T6 restart straight from PASS, then reject on the first step
        run_start(0);
        expect_st("t6_restart", 0, 1, 0, 0, 0);
        push(0, REJ, 0, 0);
        step(0, 0);
        tick(1);
        expect_st("t6_rej_sticky", 0, 0, 0, 0, REJ);

        // T3 timeout after exactly 16 CHECK cycles
        run_start(0);
        tick(15);
        expect_st("t3_before_tout", 0, 1, 0, 0, 0);
        push(0, EXP, 0, 0);
        tick(1);
        chk("t3_tout_done", donev[0], 1);
        expect_st("t3_tout", 0, 0, 0, 0, EXP);

        // T3 step advance on cycle 15; on the last step chk_vld lands in the expiring cycle
        run_start(0);
        tick(14);
        step(0, 1);
        expect_st("t3_adv15", 0, 1, 0, 1, 0);
        tick(15);
        expect_st("t3_no_tout", 0, 1, 0, 1, 0);
        push(0, ACC, 1, 1);
        step(0, 1);

        // T2 four steps, reject on step 2
        run_start(1);
        step(1, 1);
        step(1, 1);
        expect_st("t2_sel2", 1, 1, 0, 2, 0);
        push(1, REJ, 0, 2);
        step(1, 0);
        tick(1);
        expect_st("t2_sticky", 1, 0, 0, 2, REJ);

        // Timeout on a middle step keeps that step index in chk_sel
        run_start(1);
        step(1, 1);
        push(1, EXP, 0, 1);
        tick(16);
        expect_st("t3_mid_tout", 1, 0, 0, 1, EXP);

        // T5 asynchronous reset mid-run
        run_start(0);
        step(0, 1);
        expect_st("t5_pre", 0, 1, 0, 1, 0);
        #2 rst = 1'b0;
        #1;
        expect_st("t5_async", 0, 0, 0, 0, 0);
        chk("t5_async_done", donev[0], 0);
        tick(1);
        rst = 1'b1;
        tick(1);
        run_start(0);
        step(0, 1);
        push(0, ACC, 1, 1);
        step(0, 1);
        expect_st("t5_rerun", 0, 0, 1, 1, ACC);

        // T6 single step, timeout disabled
        run_start(2);
        push(2, ACC, 1, 0);
        step(2, 1);
        run_start(2);
        push(2, REJ, 0, 0);
        step(2, 0);
        run_start(2);
        tick(1000);
        expect_st("t6_no_tout", 2, 1, 0, 0, 0);
        ab[2] = 1;
        tick(1);
        ab[2] = 0;
        expect_st("t6_abort", 2, 0, 0, 0, 0);

        tick(2);
        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
